// File: rtl/mapper_stream.sv
// mapper_stream: streaming modulation mapper.
// Accepts DATA_WIDTH-bit words with a per-word scheme under valid/ready and
// serialises each word (MSB first) into one saturated I/Q symbol per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input word handshake
//   in_data, in_scheme  word bits and scheme (1 PI/2-BPSK, 2 BPSK, 3 QPSK,
//                       4 QAM16, 5 QAM64; other codes are illegal)
//   out_valid/out_ready output symbol handshake
//   out_i, out_q        signed symbol components
//   out_last, out_index last-symbol flag and symbol index within the word
//   scheme_err          one-cycle pulse after an illegal-scheme word is taken
module mapper_stream #(
  parameter int unsigned          DATA_WIDTH      = 12,
  parameter int unsigned          OUT_WIDTH       = 16,
  parameter logic [OUT_WIDTH-1:0] BPSK_AMPLITUDE  = 16'h5A82,
  parameter logic [OUT_WIDTH-1:0] QPSK_AMPLITUDE  = 16'h5A82,
  parameter logic [OUT_WIDTH-1:0] QAM16_AMPLITUDE = 16'h287A,
  parameter logic [OUT_WIDTH-1:0] QAM64_AMPLITUDE = 16'h13C0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [3:0]                    in_scheme,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_i,
  output logic signed [OUT_WIDTH-1:0]   out_q,
  output logic                          out_last,
  output logic [$clog2(DATA_WIDTH)-1:0] out_index,
  output logic                          scheme_err
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);
  localparam int unsigned PW = OUT_WIDTH + 3;
  localparam logic signed [PW-1:0] SAT_MAX = $signed({4'b0000, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN = $signed({4'b1111, {(OUT_WIDTH-1){1'b0}}});

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [3:0] {
    SCH_PI2   = 4'd1,
    SCH_BPSK  = 4'd2,
    SCH_QPSK  = 4'd3,
    SCH_QAM16 = 4'd4,
    SCH_QAM64 = 4'd5
  } scheme_t;

  // Level magnitude (1..7) times amplitude by shift-add, sign applied, then
  // saturated to the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] scale(
    input logic [2:0]           mag,
    input logic                 neg,
    input logic [OUT_WIDTH-1:0] amp
  );
    logic signed [PW-1:0] p;
    p = '0;
    if (mag[0]) p = p + $signed({3'b000, amp});
    if (mag[1]) p = p + $signed({2'b00, amp, 1'b0});
    if (mag[2]) p = p + $signed({1'b0, amp, 2'b00});
    if (neg) p = -p;
    if (p > SAT_MAX) return $signed(SAT_MAX[OUT_WIDTH-1:0]);
    if (p < SAT_MIN) return $signed(SAT_MIN[OUT_WIDTH-1:0]);
    return $signed(p[OUT_WIDTH-1:0]);
  endfunction

  state_t                        state_q, state_d;
  scheme_t                       scheme_q, scheme_d;
  logic [DATA_WIDTH-1:0]         sreg_q, sreg_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
  logic                          out_last_q, out_last_d;
  logic                          scheme_err_q, scheme_err_d;

  logic                          fire_out, accept, legal, load, step;
  logic [DATA_WIDTH-1:0]         src;
  scheme_t                       sch;
  logic [IW-1:0]                 idx, last_idx;
  logic [5:0]                    top;
  logic [2:0]                    k, mag_i, mag_q;
  logic                          neg_i, neg_q;
  logic [OUT_WIDTH-1:0]          amp;

  always_comb begin
    state_d      = state_q;
    scheme_d     = scheme_q;
    sreg_d       = sreg_q;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    out_last_d   = out_last_q;
    scheme_err_d = 1'b0;

    fire_out = out_valid_q & out_ready;
    // Also ready while the final symbol is being taken, so words chain
    // without a bubble.
    in_ready = (state_q == IDLE) | (fire_out & out_last_q);
    accept   = in_valid & in_ready;
    legal    = (in_scheme >= 4'd1) && (in_scheme <= 4'd5);
    load     = accept & legal;
    step     = fire_out & ~out_last_q;

    // One mapping datapath serves both symbol 0 of a new word (straight from
    // in_data) and later symbols (from the shift register).
    src = load ? in_data : sreg_q;
    sch = load ? scheme_t'(in_scheme) : scheme_q;
    idx = load ? '0 : idx_q + 1'b1;
    top = src[DATA_WIDTH-1 -: 6];

    k        = 3'd1;
    amp      = BPSK_AMPLITUDE;
    mag_i    = 3'd1;
    mag_q    = 3'd1;
    neg_i    = top[5];
    neg_q    = top[5];
    last_idx = IW'(DATA_WIDTH - 1);
    case (sch)
      SCH_PI2: begin
        neg_i = top[5] ^ idx[0];   // odd symbols rotated by j
      end
      SCH_BPSK: begin
      end
      SCH_QPSK: begin
        k        = 3'd2;
        amp      = QPSK_AMPLITUDE;
        neg_q    = top[4];
        last_idx = IW'(DATA_WIDTH / 2 - 1);
      end
      SCH_QAM16: begin
        k        = 3'd4;
        amp      = QAM16_AMPLITUDE;
        neg_q    = top[4];
        mag_i    = top[3] ? 3'd3 : 3'd1;
        mag_q    = top[2] ? 3'd3 : 3'd1;
        last_idx = IW'(DATA_WIDTH / 4 - 1);
      end
      SCH_QAM64: begin
        k        = 3'd6;
        amp      = QAM64_AMPLITUDE;
        neg_q    = top[4];
        mag_i    = top[3] ? (top[1] ? 3'd7 : 3'd5) : (top[1] ? 3'd1 : 3'd3);
        mag_q    = top[2] ? (top[0] ? 3'd7 : 3'd5) : (top[0] ? 3'd1 : 3'd3);
        last_idx = IW'(DATA_WIDTH / 6 - 1);
      end
      default: begin
      end
    endcase

    if (fire_out & out_last_q) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
    if (accept & ~legal) scheme_err_d = 1'b1;
    if (load | step) begin
      state_d     = RUN;
      scheme_d    = sch;
      idx_d       = idx;
      sreg_d      = src << k;
      out_valid_d = 1'b1;
      out_i_d     = scale(mag_i, neg_i, amp);
      out_q_d     = scale(mag_q, neg_q, amp);
      out_last_d  = (idx == last_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      scheme_q     <= SCH_BPSK;
      sreg_q       <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_last_q   <= 1'b0;
      scheme_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scheme_q     <= scheme_d;
      sreg_q       <= sreg_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      out_last_q   <= out_last_d;
      scheme_err_q <= scheme_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign out_last   = out_last_q;
  assign out_index  = idx_q;
  assign scheme_err = scheme_err_q;

endmodule

// File: tb/tb_mapper_stream.sv
// Testbench for mapper_stream: directed words plus randomized traffic,
// checked every cycle against a symbol-queue reference model.
module tb_mapper_stream;
  localparam int DW = 12;
  localparam int OW = 16;
  localparam int IW = $clog2(DW);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [3:0]           in_scheme;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_i;
  logic signed [OW-1:0] out_q;
  logic                 out_last;
  logic [IW-1:0]        out_index;
  logic                 scheme_err;

  mapper_stream #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_scheme(in_scheme),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_last(out_last), .out_index(out_index), .scheme_err(scheme_err)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int q; int last; int idx; } sym_t;
  sym_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   err_pending = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sgn(input int b);
    return 1 - 2 * b;
  endfunction

  function automatic int bits_per(input int sch);
    case (sch)
      3: return 2;
      4: return 4;
      5: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic sym_t model_sym(input logic [DW-1:0] d, input int sch, input int n);
    int k, a, li, lq, pos;
    int b[6];
    sym_t r;
    k = bits_per(sch);
    case (sch)
      3: a = 'h5A82;
      4: a = 'h287A;
      5: a = 'h13C0;
      default: a = 'h5A82;
    endcase
    for (int j = 0; j < 6; j++) begin
      pos  = DW - 1 - n * k - j;
      b[j] = (pos >= 0) ? int'(d[pos]) : 0;
    end
    case (sch)
      1: begin li = sgn(b[0]); lq = li; if (n % 2 == 1) li = -li; end
      3: begin li = sgn(b[0]); lq = sgn(b[1]); end
      4: begin li = sgn(b[0]) * (2 - sgn(b[2])); lq = sgn(b[1]) * (2 - sgn(b[3])); end
      5: begin
        li = sgn(b[0]) * (4 - sgn(b[2]) * (2 - sgn(b[4])));
        lq = sgn(b[1]) * (4 - sgn(b[3]) * (2 - sgn(b[5])));
      end
      default: begin li = sgn(b[0]); lq = li; end
    endcase
    r.i    = sat(li * a);
    r.q    = sat(lq * a);
    r.idx  = n;
    r.last = int'(n == DW / k - 1);
    return r;
  endfunction

  function automatic void push_word(input logic [DW-1:0] d, input int sch);
    for (int n = 0; n < DW / bits_per(sch); n++) expq.push_back(model_sym(d, sch, n));
  endfunction

  // Compare process: sampled at negedge, inputs only change at posedge+1.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_i", int'(out_i), 0);
        chk("rst_out_q", int'(out_q), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_scheme_err", int'(scheme_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        expq.delete();
        err_pending = 1'b0;
      end else begin
        n = expq.size();
        chk("out_valid", int'(out_valid), int'(n != 0));
        chk("in_ready", int'(in_ready), int'(n == 0 || (n == 1 && out_ready)));
        chk("scheme_err", int'(scheme_err), int'(err_pending));
        if (out_valid && n != 0) begin
          chk("out_i", int'(out_i), expq[0].i);
          chk("out_q", int'(out_q), expq[0].q);
          chk("out_last", int'(out_last), expq[0].last);
          chk("out_index", int'(out_index), expq[0].idx);
          if (out_ready) void'(expq.pop_front());
        end
        err_pending = 1'b0;
        if (in_valid && in_ready) begin
          if (in_scheme >= 4'd1 && in_scheme <= 4'd5) push_word(in_data, int'(in_scheme));
          else err_pending = 1'b1;
        end
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic [3:0] s);
    in_data   = d;
    in_scheme = s;
    in_valid  = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    for (int t = 0; t < 50; t++) begin
      if (out_valid && int'(out_index) == target) return;
      @(posedge clk);
      #1;
    end
    chk("wait_idx_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (!out_valid) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  initial begin
    sym_t m;
    bit   hs;
    int   r;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_scheme = '0; out_ready = 1'b1;
    #1 rst = 1'b1;

    // Hand-computed pins on the reference model.
    m = model_sym(12'b101010101010, 2, 0);  chk("pin_bpsk0", m.i, -23170);
    m = model_sym(12'b101010101010, 2, 1);  chk("pin_bpsk1", m.q, 23170);
    m = model_sym(12'b110010101011, 1, 1);  chk("pin_pi2_1i", m.i, 23170);
    chk("pin_pi2_1q", m.q, -23170);
    m = model_sym(12'b110010101011, 1, 3);  chk("pin_pi2_3i", m.i, -23170);
    m = model_sym(12'b010110100110, 4, 0);  chk("pin_q16_0i", m.i, 10362);
    chk("pin_q16_0q", m.q, -31086);
    m = model_sym(12'b010110100110, 4, 2);  chk("pin_q16_2q", m.q, -10362);
    chk("pin_q16_2last", m.last, 1);
    m = model_sym(12'b101010101010, 5, 1);  chk("pin_q64_1i", m.i, -32768);
    chk("pin_q64_1q", m.q, 15168);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_word(12'b101010101010, 4'd2); drain();
    send_word(12'b110010101011, 4'd1); drain();
    send_word(12'b010110100110, 4'd4); drain();
    send_word(12'b101010101010, 4'd5); drain();

    // QPSK with a 3-cycle stall on symbol 2, then a chained second word.
    send_word(12'h9C3, 4'd3);
    wait_idx(2);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(12'h5A7, 4'd3);
    drain();

    // Illegal scheme, then reset in the middle of a QAM16 word.
    send_word(12'hABC, 4'b0111);
    repeat (3) @(posedge clk);
    #1;
    send_word(12'b010110100110, 4'd4);
    wait_idx(1);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(12'h3C5, 4'd5); drain();

    // Randomized traffic with random backpressure and occasional illegal codes.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (hs) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 9));
        in_data = DW'($urandom);
        if (r < 8) in_scheme = 4'(r % 5 + 1);
        else if (r == 8) in_scheme = 4'd0;
        else in_scheme = 4'($urandom_range(6, 15));
        in_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
